// File: rtl/sensor_ascii_tx_formatter_pkg.sv
// rtl/sensor_ascii_tx_formatter_pkg.sv - shared constants, state type and ASCII helpers for the sensor frame formatter
package sensor_ascii_tx_formatter_pkg;

    localparam int BIN_W      = 14;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_TAG_D = 8'h44;
    localparam logic [7:0] ASCII_TAG_T = 8'h54;
    localparam logic [7:0] ASCII_TAG_H = 8'h48;
    localparam logic [7:0] ASCII_TAG_X = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } fmt_state_t;

    // Frame prefix character for a 2-bit sensor tag
    function automatic logic [7:0] tag_char(input logic [1:0] tag);
        logic [7:0] c;
        case (tag)
            2'd0:    c = ASCII_TAG_D;
            2'd1:    c = ASCII_TAG_T;
            2'd2:    c = ASCII_TAG_H;
            default: c = ASCII_TAG_X;
        endcase
        return c;
    endfunction

    // ASCII code of a single BCD digit
    function automatic logic [7:0] digit_char(input logic [3:0] digit);
        return ASCII_ZERO + {4'b0000, digit};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter, one bit per cycle
module bin2bcd_seq
    import sensor_ascii_tx_formatter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift the whole register left
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adj;
        adj = sr;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (adj[BIN_W + 4*d +: 4] >= 4'd5) begin
                adj[BIN_W + 4*d +: 4] = adj[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    logic [SR_W-1:0]  sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // The first iteration runs on the start edge so the result is ready BIN_W cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_start && !busy_q) begin
                sr_q   <= dabble_step({{BCD_W{1'b0}}, i_bin});
                cnt_q  <= CNT_W'(BIN_W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sr_q  <= dabble_step(sr_q);
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/sensor_ascii_tx_formatter.sv
// rtl/sensor_ascii_tx_formatter.sv - formats a tagged sensor value as an ASCII frame into the UART TX FIFO
module sensor_ascii_tx_formatter
    import sensor_ascii_tx_formatter_pkg::*;
#(
    parameter int SAT_VALUE = 9999,
    parameter int SEND_CRLF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_data,
    input  logic [1:0]       i_tag,
    input  logic             i_full,
    output logic             o_push,
    output logic [7:0]       o_push_data,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [BIN_W-1:0] SAT_W    = BIN_W'(SAT_VALUE);
    localparam logic [2:0]       LAST_IDX = (SEND_CRLF != 0) ? 3'd7 : 3'd5;

    fmt_state_t       state_q;
    fmt_state_t       state_d;
    logic [1:0]       tag_q;
    logic [2:0]       idx_q;
    logic             accept;
    logic [BIN_W-1:0] sat_value;
    logic             bcd_busy;
    logic             bcd_done;
    logic [BCD_W-1:0] bcd;
    logic [7:0]       byte_sel;

    assign accept    = (state_q == ST_IDLE) && i_start;
    assign sat_value = (i_data > SAT_W) ? SAT_W : i_data;

    // The converter's shift register holds the latched (saturated) value for the frame in flight
    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst),
        .i_start (accept),
        .i_bin   (sat_value),
        .o_busy  (bcd_busy),
        .o_done  (bcd_done),
        .o_bcd   (bcd)
    );

    // State, latched tag and byte index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tag_q   <= 2'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q <= i_tag;
            end
            if (state_q != ST_SEND) begin
                idx_q <= 3'd0;
            end else if (o_push) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // Next-state logic and FIFO push strobe
    always_comb begin
        state_d = state_q;
        o_push  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (bcd_done) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                o_push = ~i_full;
                if (!i_full && idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte mux: tag, colon, four digits most significant first, then optional CR LF
    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            3'd0:    byte_sel = tag_char(tag_q);
            3'd1:    byte_sel = ASCII_COLON;
            3'd2:    byte_sel = digit_char(bcd[15:12]);
            3'd3:    byte_sel = digit_char(bcd[11:8]);
            3'd4:    byte_sel = digit_char(bcd[7:4]);
            3'd5:    byte_sel = digit_char(bcd[3:0]);
            3'd6:    byte_sel = ASCII_CR;
            default: byte_sel = ASCII_LF;
        endcase
    end

    assign o_push_data = (state_q == ST_SEND) ? byte_sel : 8'h00;
    assign o_busy      = (state_q != ST_IDLE) || bcd_busy;
    assign o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sensor_ascii_tx_formatter.sv
// tb/tb_sensor_ascii_tx_formatter.sv - self-checking bench for the sensor ASCII frame formatter
module tb_sensor_ascii_tx_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [13:0] i_data;
    logic [1:0]  i_tag;
    logic        i_full;

    logic        push_a, busy_a, done_a;
    logic [7:0]  data_a;
    logic        push_b, busy_b, done_b;
    logic [7:0]  data_b;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int viol  = 0;

    logic [7:0] cap_q[$];
    int         stamp_q[$];
    int         done_q[$];
    logic [7:0] exp_q[$];

    logic       m_push, m_busy, m_done;
    logic [7:0] m_data;

    sensor_ascii_tx_formatter #(.SAT_VALUE(9999), .SEND_CRLF(1)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data), .i_tag(i_tag), .i_full(i_full),
        .o_push(push_a), .o_push_data(data_a), .o_busy(busy_a), .o_done(done_a)
    );

    sensor_ascii_tx_formatter #(.SAT_VALUE(9999), .SEND_CRLF(0)) dut6 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data), .i_tag(i_tag), .i_full(i_full),
        .o_push(push_b), .o_push_data(data_b), .o_busy(busy_b), .o_done(done_b)
    );

    assign m_push = (sel != 0) ? push_b : push_a;
    assign m_data = (sel != 0) ? data_b : data_a;
    assign m_busy = (sel != 0) ? busy_b : busy_a;
    assign m_done = (sel != 0) ? done_b : done_a;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture pushed bytes and done pulses of the selected instance, stamped with their cycle number
    always @(negedge clk) begin
        if (rst) begin
            if (m_push) begin
                cap_q.push_back(m_data);
                stamp_q.push_back(cyc + 1);
                if (i_full) viol++;
            end
            if (m_done) begin
                done_q.push_back(cyc + 1);
                if (!m_busy) viol++;
            end
        end
    end

    typedef struct {
        logic [13:0] data;
        logic [1:0]  tag;
        logic [63:0] bytes;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference frame from the arithmetic rules: saturate, split into decimal digits, add ASCII framing
    task automatic model(input int v, input int t, input int crlf);
        logic [7:0] tags[4];
        tags[0] = 8'h44; tags[1] = 8'h54; tags[2] = 8'h48; tags[3] = 8'h58;
        if (v > 9999) v = 9999;
        exp_q.delete();
        exp_q.push_back(tags[t]);
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'(8'h30 + (v / 1000) % 10));
        exp_q.push_back(8'(8'h30 + (v / 100) % 10));
        exp_q.push_back(8'(8'h30 + (v / 10) % 10));
        exp_q.push_back(8'(8'h30 + v % 10));
        if (crlf != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    function automatic logic full_for(input int mode, input int off);
        if (mode == 1) return ($urandom_range(0, 2) == 0);
        if (mode == 2) return (off >= 17 && off <= 19) || (off >= 25 && off <= 27);
        return 1'b0;
    endfunction

    // Start one frame and wait (bounded) for its done pulse; mode selects the i_full / stray-start pattern
    task automatic run(input logic [13:0] d, input logic [1:0] t, input int mode, input bit now, output int n);
        int off;
        cap_q.delete(); stamp_q.delete(); done_q.delete(); viol = 0;
        if (!now) begin
            @(posedge clk); #1;
        end
        i_start = 1'b1; i_data = d; i_tag = t;
        @(posedge clk); #1;
        n = cyc;
        i_start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            off = cyc + 1 - n;
            i_full = full_for(mode, off);
            if (mode == 3) begin
                i_start = (off == 5 || off == 17);
                i_data  = 14'($urandom);
                i_tag   = 2'd3;
            end
            @(posedge clk); #1;
            if (done_q.size() > 0) break;
        end
        i_full = 1'b0; i_start = 1'b0;
    endtask

    task automatic check_frame(input string name, input int n, input int first_off, input int last_off, input int done_off);
        int first, last, dn;
        chk({name, " len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk($sformatf("%s byte%0d", name, i), cap_q[i], exp_q[i]);
        first = (stamp_q.size() > 0) ? stamp_q[0] - n : -1;
        last  = (stamp_q.size() > 0) ? stamp_q[stamp_q.size()-1] - n : -1;
        dn    = (done_q.size() > 0) ? done_q[0] - n : -1;
        chk({name, " done_count"}, done_q.size(), 1);
        chk({name, " done_after_last"}, dn, last + 1);
        chk({name, " protocol"}, viol, 0);
        if (first_off >= 0) begin
            chk({name, " first_push"}, first, first_off);
            chk({name, " last_push"}, last, last_off);
            chk({name, " done_at"}, dn, done_off);
        end
    endtask

    initial begin
        int n, prev_done;
        int exp_st[8];

        vecs[0] = '{14'd1234,  2'd0, 64'h44_3A_31_32_33_34_0D_0A};
        vecs[1] = '{14'd16383, 2'd2, 64'h48_3A_39_39_39_39_0D_0A};
        vecs[2] = '{14'd0,     2'd1, 64'h54_3A_30_30_30_30_0D_0A};
        vecs[3] = '{14'd9999,  2'd3, 64'h58_3A_39_39_39_39_0D_0A};
        vecs[4] = '{14'd10000, 2'd0, 64'h44_3A_39_39_39_39_0D_0A};
        vecs[5] = '{14'd1000,  2'd2, 64'h48_3A_31_30_30_30_0D_0A};
        vecs[6] = '{14'd42,    2'd0, 64'h44_3A_30_30_34_32_0D_0A};

        rst = 1'b0; i_start = 1'b0; i_data = '0; i_tag = '0; i_full = 1'b0;
        #12;
        chk("reset push", push_a, 0);
        chk("reset data", data_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset done", done_a, 0);
        chk("reset push6", push_b, 0);
        @(negedge clk); rst = 1'b1;

        // Fixed vectors with hand-computed frames, no back-pressure
        for (int v = 0; v < 7; v++) begin
            run(vecs[v].data, vecs[v].tag, 0, 1'b0, n);
            exp_q.delete();
            for (int i = 0; i < 8; i++) exp_q.push_back(vecs[v].bytes[63 - 8*i -: 8]);
            check_frame($sformatf("vec%0d", v), n, 15, 22, 23);
            chk($sformatf("vec%0d busy_after", v), busy_a, 0);
        end

        // Back-pressure at the 3rd and the last byte
        run(14'd507, 2'd1, 2, 1'b0, n);
        model(507, 1, 1);
        check_frame("bp507", n, 15, 28, 29);
        exp_st = '{15, 16, 20, 21, 22, 23, 24, 28};
        for (int i = 0; i < 8 && i < stamp_q.size(); i++)
            chk($sformatf("bp507 stamp%0d", i), stamp_q[i] - n, exp_st[i]);

        // Stray starts during CONVERT and SEND are ignored; start right after DONE is accepted
        run(14'd1234, 2'd0, 3, 1'b0, n);
        model(1234, 0, 1);
        check_frame("ignore", n, 15, 22, 23);
        prev_done = (done_q.size() > 0) ? done_q[0] : 0;
        run(14'd8765, 2'd2, 0, 1'b1, n);
        model(8765, 2, 1);
        chk("restart accept_cycle", n - prev_done, 1);
        check_frame("restart", n, 15, 22, 23);

        // Randomized frames under random back-pressure against the arithmetic model
        for (int r = 0; r < 16; r++) begin
            logic [13:0] d;
            logic [1:0]  t;
            d = (r % 4 == 0) ? 14'($urandom_range(9990, 16383)) : 14'($urandom_range(0, 16383));
            t = 2'($urandom);
            run(d, t, 1, 1'b0, n);
            model(int'(d), int'(t), 1);
            check_frame($sformatf("rnd%0d", r), n, -1, -1, -1);
        end

        // Asynchronous reset in the middle of SEND
        cap_q.delete(); stamp_q.delete(); done_q.delete();
        @(posedge clk); #1;
        i_start = 1'b1; i_data = 14'd1234; i_tag = 2'd0;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (cap_q.size() >= 3) break;
        end
        chk("abort bytes_before", cap_q.size(), 3);
        #2 rst = 1'b0;
        #1;
        chk("abort push", push_a, 0);
        chk("abort data", data_a, 0);
        chk("abort busy", busy_a, 0);
        chk("abort done", done_a, 0);
        @(negedge clk); rst = 1'b1;
        run(14'd42, 2'd0, 0, 1'b0, n);
        model(42, 0, 1);
        check_frame("after_reset", n, 15, 22, 23);

        // Six-byte frames from the instance without CR LF
        repeat (4) @(posedge clk);
        sel = 1;
        run(14'd9999, 2'd3, 0, 1'b0, n);
        model(9999, 3, 0);
        check_frame("nocrlf9999", n, 15, 20, 21);
        run(14'd123, 2'd2, 0, 1'b0, n);
        model(123, 2, 0);
        check_frame("nocrlf123", n, 15, 20, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
